// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory port
//               arbiter. Defines the owner tag that travels with every memory
//               access. It also holds the legal ranges for the latency and
//               starvation parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Owner of an in-flight memory access. OWN_NONE marks an idle slot.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_ME   = 2'd2
    } owner_t;

    localparam int MEM_LAT_MIN      = 1;
    localparam int MEM_LAT_MAX      = 4;
    localparam int STARVE_LIMIT_MIN = 1;
    localparam int STARVE_LIMIT_MAX = 15;
    // This width is wide enough for any legal STARVE_LIMIT.
    localparam int STARVE_CNT_W     = 4;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_tag_pipe.sv
// ============================================================================
// Module      : mem_arb_tag_pipe
// Description : DEPTH-stage shift register of owner tags. The tag written on a
//               grant cycle appears on tag_o exactly DEPTH cycles later. This
//               tells the arbiter which requester the returning read data
//               belongs to.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset (clears all stages)
//               tag_i - owner of the access granted this cycle
//               tag_o - owner of the access whose data returns this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule : mem_arb_tag_pipe

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM between the IF (fetch)
//               and ME (load/store) requesters.
//               - ME has fixed priority. IF is forced to win after
//                 STARVE_LIMIT consecutive losses.
//               - Accesses are pipelined: one new grant per cycle at most.
//               - Each requester may have only one access outstanding.
//               - Read data is routed back to its owner MEM_LATENCY cycles
//                 after the grant.
// Optional    : MEM_ARB_PERF_EN - adds the saturating stall-cycle counters
//               if_stall_cnt / me_stall_cnt.
// Ports       : clk, reset (async active-low)
//               if_req/if_addr -> if_gnt, if_rvalid, if_rdata
//               me_req/me_we/me_addr/me_wdata -> me_gnt, me_rvalid, me_rdata
//               mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM
//               stall_if/stall_me -> pipeline hold controls
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // Fetch requester
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    // Load/store requester
    input  logic                  me_req,
    input  logic                  me_we,
    input  logic [ADDR_WIDTH-1:0] me_addr,
    input  logic [DATA_WIDTH-1:0] me_wdata,
    output logic                  me_gnt,
    output logic                  me_rvalid,
    output logic [DATA_WIDTH-1:0] me_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]           if_stall_cnt,
    output logic [31:0]           me_stall_cnt,
`endif
    // Memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // Pipeline stalls
    output logic                  stall_if,
    output logic                  stall_me
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY out of range");
    end
    if (STARVE_LIMIT < STARVE_LIMIT_MIN || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range");
    end

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    pend_if_q, pend_if_d;
    logic                    pend_me_q, pend_me_d;
    owner_t                  tag_in, tag_out;

    logic if_rv, me_rv;
    logic if_elig, me_elig, force_if;
    logic if_gnt_w, me_gnt_w;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign if_rv = (tag_out == OWN_IF);
    assign me_rv = (tag_out == OWN_ME);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A requester can be granted only when it has nothing in flight, or
    // when its only in-flight access completes this cycle (back-to-back).
    // The reset term keeps every grant-derived output low while reset is
    // held, independent of the clock.
    assign if_elig  = reset & if_req & (~pend_if_q | if_rv);
    assign me_elig  = reset & me_req & (~pend_me_q | me_rv);
    assign force_if = if_elig & (starve_cnt_q == LIMIT);
    assign me_gnt_w = me_elig & ~force_if;
    assign if_gnt_w = if_elig & ~me_gnt_w;

    assign tag_in = me_gnt_w ? OWN_ME : (if_gnt_w ? OWN_IF : OWN_NONE);

    mem_arb_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // ------------------------------------------------------------------
    // Starvation counter and pending flags
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt_w) begin
            starve_cnt_d = '0;
        end else if (me_gnt_w && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    assign pend_if_d = if_gnt_w | (pend_if_q & ~if_rv);
    assign pend_me_d = me_gnt_w | (pend_me_q & ~me_rv);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            pend_if_q    <= 1'b0;
            pend_me_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pend_if_q    <= pend_if_d;
            pend_me_q    <= pend_me_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_gnt    = if_gnt_w;
    assign me_gnt    = me_gnt_w;
    assign if_rvalid = if_rv;
    assign me_rvalid = me_rv;
    assign if_rdata  = reset ? mem_rdata : '0;
    assign me_rdata  = reset ? mem_rdata : '0;

    assign mem_en    = if_gnt_w | me_gnt_w;
    assign mem_we    = me_we & me_gnt_w;
    assign mem_addr  = me_gnt_w ? me_addr : (if_gnt_w ? if_addr : '0);
    assign mem_wdata = reset ? me_wdata : '0;

    assign stall_if  = reset & ((if_req & ~if_gnt_w) | (pend_if_q & ~if_rv));
    assign stall_me  = reset & ((me_req & ~me_gnt_w) | (pend_me_q & ~me_rv));

`ifdef MEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating stall-cycle counters
    // ------------------------------------------------------------------
    logic [31:0] if_stall_cnt_q, me_stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_cnt_q <= '0;
            me_stall_cnt_q <= '0;
        end else begin
            if (stall_if && (if_stall_cnt_q != 32'hFFFF_FFFF)) begin
                if_stall_cnt_q <= if_stall_cnt_q + 32'd1;
            end
            if (stall_me && (me_stall_cnt_q != 32'hFFFF_FFFF)) begin
                me_stall_cnt_q <= me_stall_cnt_q + 32'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_cnt_q;
    assign me_stall_cnt = me_stall_cnt_q;
`endif

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. It drives two
//               instances:
//               - dut0: MEM_LATENCY=1, STARVE_LIMIT=4
//               - dut1: MEM_LATENCY=3, STARVE_LIMIT=1
//               A RAM model sits behind each memory port. A per-requester
//               transaction model predicts every output on every cycle.
//               Directed scenarios with literal expectations come first,
//               followed by random traffic with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT0 = 1, LIM0 = 4;
    localparam int LAT1 = 3, LIM1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [1:0]       if_req, if_gnt, if_rvalid;
    logic [1:0]       me_req, me_we, me_gnt, me_rvalid;
    logic [1:0]       mem_en, mem_we, stall_if, stall_me;
    logic [1:0][31:0] if_addr, if_rdata, me_addr, me_wdata, me_rdata;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [1:0][31:0] if_stall_cnt, me_stall_cnt;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT0), .STARVE_LIMIT(LIM0)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .me_req(me_req[0]), .me_we(me_we[0]), .me_addr(me_addr[0]), .me_wdata(me_wdata[0]),
        .me_gnt(me_gnt[0]), .me_rvalid(me_rvalid[0]), .me_rdata(me_rdata[0]),
`ifdef MEM_ARB_PERF_EN
        .if_stall_cnt(if_stall_cnt[0]), .me_stall_cnt(me_stall_cnt[0]),
`endif
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .stall_if(stall_if[0]), .stall_me(stall_me[0])
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT1), .STARVE_LIMIT(LIM1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .me_req(me_req[1]), .me_we(me_we[1]), .me_addr(me_addr[1]), .me_wdata(me_wdata[1]),
        .me_gnt(me_gnt[1]), .me_rvalid(me_rvalid[1]), .me_rdata(me_rdata[1]),
`ifdef MEM_ARB_PERF_EN
        .if_stall_cnt(if_stall_cnt[1]), .me_stall_cnt(me_stall_cnt[1]),
`endif
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .stall_if(stall_if[1]), .stall_me(stall_me[1])
    );

    // ------------------------------------------------------------------
    // Reference model state (per instance)
    // ------------------------------------------------------------------
    int          lat [2];
    int          lim [2];
    int          scnt [2];                 // consecutive IF losses
    bit          iout [2], mout [2];       // access in flight per requester
    bit          mst [2];                  // ME in-flight access is a store
    longint      idue [2], mdue [2];       // cycle its response is due
    logic [31:0] idat [2], mdat [2];       // data it must return
    bit          eig [2], emg [2];         // predicted grants of last cycle
    logic [31:0] mm  [2][16];              // model's view of memory
    logic [31:0] ram [2][16];              // RAM behind the DUT port
    logic [31:0] rp  [2][4];               // RAM read-data delay line
`ifdef MEM_ARB_PERF_EN
    logic [31:0] pci [2], pcm [2];
`endif
    longint      cyc;
    int          tests, fails;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_check(input int k);
        bit rvi, rvm, iel, mel, frc, ig, mg, sti, stm;
        int ia, ma;
        if (!reset) begin
            chk("rst_if_gnt", k, if_gnt[k], 0);       chk("rst_me_gnt", k, me_gnt[k], 0);
            chk("rst_if_rvalid", k, if_rvalid[k], 0); chk("rst_me_rvalid", k, me_rvalid[k], 0);
            chk("rst_mem_en", k, mem_en[k], 0);       chk("rst_mem_we", k, mem_we[k], 0);
            chk("rst_mem_addr", k, mem_addr[k], 0);   chk("rst_mem_wdata", k, mem_wdata[k], 0);
            chk("rst_if_rdata", k, if_rdata[k], 0);   chk("rst_me_rdata", k, me_rdata[k], 0);
            chk("rst_stall_if", k, stall_if[k], 0);   chk("rst_stall_me", k, stall_me[k], 0);
`ifdef MEM_ARB_PERF_EN
            chk("rst_if_stall_cnt", k, if_stall_cnt[k], 0);
            chk("rst_me_stall_cnt", k, me_stall_cnt[k], 0);
            pci[k] = 0; pcm[k] = 0;
`endif
            scnt[k] = 0; iout[k] = 0; mout[k] = 0; eig[k] = 0; emg[k] = 0;
        end else begin
            rvi = iout[k] && (idue[k] == cyc);
            rvm = mout[k] && (mdue[k] == cyc);
            iel = if_req[k] && (!iout[k] || rvi);
            mel = me_req[k] && (!mout[k] || rvm);
            frc = iel && (scnt[k] == lim[k]);
            mg  = mel && !frc;
            ig  = iel && !mg;
            sti = (if_req[k] && !ig) || (iout[k] && !rvi);
            stm = (me_req[k] && !mg) || (mout[k] && !rvm);

            chk("if_gnt", k, if_gnt[k], ig);
            chk("me_gnt", k, me_gnt[k], mg);
            chk("mem_en", k, mem_en[k], ig | mg);
            chk("mem_we", k, mem_we[k], mg & me_we[k]);
            if (ig || mg) chk("mem_addr", k, mem_addr[k], mg ? me_addr[k] : if_addr[k]);
            if (mg && me_we[k]) chk("mem_wdata", k, mem_wdata[k], me_wdata[k]);
            chk("if_rvalid", k, if_rvalid[k], rvi);
            chk("me_rvalid", k, me_rvalid[k], rvm);
            chk("stall_if", k, stall_if[k], sti);
            chk("stall_me", k, stall_me[k], stm);
            if (rvi) chk("if_rdata", k, if_rdata[k], idat[k]);
            if (rvm && !mst[k]) chk("me_rdata", k, me_rdata[k], mdat[k]);
`ifdef MEM_ARB_PERF_EN
            chk("if_stall_cnt", k, if_stall_cnt[k], pci[k]);
            chk("me_stall_cnt", k, me_stall_cnt[k], pcm[k]);
            if (sti && pci[k] != 32'hFFFF_FFFF) pci[k] = pci[k] + 1;
            if (stm && pcm[k] != 32'hFFFF_FFFF) pcm[k] = pcm[k] + 1;
`endif
            // Advance to the next cycle.
            if (rvi) iout[k] = 0;
            if (rvm) mout[k] = 0;
            ia = int'(if_addr[k][5:2]);
            ma = int'(me_addr[k][5:2]);
            if (ig) begin
                iout[k] = 1; idue[k] = cyc + lat[k]; idat[k] = mm[k][ia];
            end
            if (mg) begin
                mout[k] = 1; mdue[k] = cyc + lat[k]; mst[k] = me_we[k]; mdat[k] = mm[k][ma];
                if (me_we[k]) mm[k][ma] = me_wdata[k];
            end
            if (!if_req[k] || ig) scnt[k] = 0;
            else if (mg && scnt[k] < lim[k]) scnt[k] = scnt[k] + 1;
            eig[k] = ig; emg[k] = mg;
        end
    endtask

    // Single-port RAM with a lat-cycle read pipeline. It acts on the port
    // signals that are valid for the upcoming clock edge.
    task automatic ram_step(input int k);
        for (int j = 3; j > 0; j--) rp[k][j] = rp[k][j-1];
        if (mem_en[k] && !mem_we[k]) rp[k][0] = ram[k][mem_addr[k][5:2]];
        else                         rp[k][0] = $urandom;
        if (mem_en[k] && mem_we[k])  ram[k][mem_addr[k][5:2]] = mem_wdata[k];
        mem_rdata[k] = rp[k][lat[k]-1];
    endtask

    // Called right after a falling edge, once this cycle's inputs are set.
    task automatic settle();
        #2;
        for (int k = 0; k < 2; k++) begin
            model_check(k);
            ram_step(k);
        end
        cyc++;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        lat[0] = LAT0; lat[1] = LAT1;
        lim[0] = LIM0; lim[1] = LIM1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                ram[k][i] = 32'hC0DE_0000 + i;
                mm[k][i]  = 32'hC0DE_0000 + i;
            end
            for (int j = 0; j < 4; j++) rp[k][j] = '0;
            scnt[k] = 0; iout[k] = 0; mout[k] = 0; eig[k] = 0; emg[k] = 0;
            idue[k] = 0; mdue[k] = 0; mst[k] = 0; idat[k] = '0; mdat[k] = '0;
`ifdef MEM_ARB_PERF_EN
            pci[k] = 0; pcm[k] = 0;
`endif
        end
        mem_rdata = '0;
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b0;
        if_req = 2'b11; me_req = 2'b11; me_we = 2'b11;
        if_addr = '0; me_addr = '0; me_wdata = '0;

        // Reset with requests asserted: every output must stay low.
        nxt();
        settle();
        chk("t0_if_gnt_in_reset", 0, if_gnt[0], 0);
        chk("t0_mem_en_in_reset", 1, mem_en[1], 0);
        nxt();
        if_req = '0; me_req = '0; me_we = '0;
        reset = 1'b1;
        settle(); nxt();

        // Test 1: a single fetch on dut0 (latency 1).
        if_req[0] = 1'b1; if_addr[0] = 32'h0040_0000;
        settle();
        chk("t1_if_gnt", 0, if_gnt[0], 1);
        chk("t1_mem_en", 0, mem_en[0], 1);
        chk("t1_mem_addr", 0, mem_addr[0], 32'h0040_0000);
        nxt();
        if_req[0] = 1'b0;
        settle();
        chk("t1_if_rvalid", 0, if_rvalid[0], 1);
        chk("t1_if_rdata", 0, if_rdata[0], 32'hC0DE_0000);
        chk("t1_stall_if", 0, stall_if[0], 0);
        nxt();

        // Test 2: IF and ME collide; ME wins first.
        if_req[0] = 1'b1; if_addr[0] = 32'h0040_0004;
        me_req[0] = 1'b1; me_we[0] = 1'b0; me_addr[0] = 32'h1001_0000;
        settle();
        chk("t2_me_gnt", 0, me_gnt[0], 1);
        chk("t2_if_gnt", 0, if_gnt[0], 0);
        chk("t2_stall_if", 0, stall_if[0], 1);
        nxt();
        me_req[0] = 1'b0;
        settle();
        chk("t2_me_rvalid", 0, me_rvalid[0], 1);
        chk("t2_me_rdata", 0, me_rdata[0], 32'hC0DE_0000);
        chk("t2_if_gnt_t1", 0, if_gnt[0], 1);
        nxt();
        if_req[0] = 1'b0;
        settle();
        chk("t2_if_rvalid", 0, if_rvalid[0], 1);
        chk("t2_if_rdata", 0, if_rdata[0], 32'hC0DE_0001);
        nxt();

        // Test 3: ME continuously requesting; IF wins on its 5th waiting
        // cycle. After a break, IF again needs 4 losses.
        me_req[0] = 1'b1; me_addr[0] = 32'h1001_0008;
        if_req[0] = 1'b1; if_addr[0] = 32'h0040_0008;
        for (int i = 1; i <= 13; i++) begin
            settle();
            chk("t3_if_gnt", 0, if_gnt[0], (i == 5 || i == 13) ? 1 : 0);
            chk("t3_me_gnt", 0, me_gnt[0], (i == 5 || i == 13) ? 0 : 1);
            nxt();
            if_req[0] = (i < 5 || (i >= 8 && i < 13)) ? 1'b1 : 1'b0;
        end
        me_req[0] = 1'b0;
        settle(); nxt();
        settle(); nxt();

        // Test 4: dut1 (latency 3): IF then ME; responses in grant order.
        if_req[1] = 1'b1; if_addr[1] = 32'h0040_0008;
        settle();
        chk("t4_if_gnt", 1, if_gnt[1], 1);
        nxt();
        if_req[1] = 1'b0;
        me_req[1] = 1'b1; me_we[1] = 1'b0; me_addr[1] = 32'h1001_000C;
        settle();
        chk("t4_me_gnt", 1, me_gnt[1], 1);
        nxt();
        me_req[1] = 1'b0;
        settle();
        chk("t4_if_rvalid_early", 1, if_rvalid[1], 0);
        nxt();
        settle();
        chk("t4_if_rvalid", 1, if_rvalid[1], 1);
        chk("t4_if_rdata", 1, if_rdata[1], 32'hC0DE_0002);
        chk("t4_me_rvalid_early", 1, me_rvalid[1], 0);
        nxt();
        settle();
        chk("t4_me_rvalid", 1, me_rvalid[1], 1);
        chk("t4_me_rdata", 1, me_rdata[1], 32'hC0DE_0003);
        nxt();

        // Test 5: store on dut1, then reset while the store is in flight.
        me_req[1] = 1'b1; me_we[1] = 1'b1; me_addr[1] = 32'h1001_0010; me_wdata[1] = 32'hDEAD_BEEF;
        settle();
        chk("t5_me_gnt", 1, me_gnt[1], 1);
        chk("t5_mem_we", 1, mem_we[1], 1);
        nxt();
        me_req[1] = 1'b0; me_we[1] = 1'b0;
        reset = 1'b0;
        settle();
        chk("t5_stall_me_reset", 1, stall_me[1], 0);
        nxt();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_no_rvalid", 1, me_rvalid[1], 0);
            nxt();
        end
        // The store reached memory before the reset; read it back.
        me_req[1] = 1'b1; me_addr[1] = 32'h1001_0010;
        settle(); nxt();
        me_req[1] = 1'b0;
        settle(); nxt();
        settle(); nxt();
        settle();
        chk("t5_load_rvalid", 1, me_rvalid[1], 1);
        chk("t5_load_rdata", 1, me_rdata[1], 32'hDEAD_BEEF);
        nxt();

        // Random traffic. A requester holds its request until it is granted,
        // and may re-request at once (including while its access is in flight).
        if_req = '0; me_req = '0;
        for (int k = 0; k < 2; k++) begin eig[k] = 0; emg[k] = 0; end
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!if_req[k] || eig[k]) begin
                    if_req[k]  = ($urandom_range(0, 99) < 60);
                    if_addr[k] = $urandom;
                end
                if (!me_req[k] || emg[k]) begin
                    me_req[k]   = ($urandom_range(0, 99) < 65);
                    me_we[k]    = ($urandom_range(0, 99) < 35);
                    me_addr[k]  = $urandom;
                    me_wdata[k] = $urandom;
                end
            end
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            settle();
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire
